// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues word reads for pc_in and buffers {pc, instr} pairs for decode.
// Define FETCH_MISALIGN_TRAP_EN to turn misaligned PCs into trap marker entries instead of fetches.
module instr_fetch #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  output logic            pc_advance,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_pc,
  output logic [XLEN-1:0] fetch_instr,
  input  logic            fetch_ready,
  output logic            fetch_misaligned
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DROP} state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            misaligned;
  } entry_t;

  state_e           state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic [XLEN-1:0]  mem_addr_q, mem_addr_d;
  logic             pc_advance_q, pc_advance_d;
  logic             trap_q, trap_d;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t           fifo_q [FIFO_DEPTH];
  entry_t           fifo_d [FIFO_DEPTH];

  logic             push;
  logic             pop;
  entry_t           push_entry;
  logic [CNT_W-1:0] wr_idx;

  // Request/response sequencing; at most one read is outstanding, so IDLE's room check covers it.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    pc_advance_d = 1'b0;
    trap_d       = trap_q;
    push         = 1'b0;
    push_entry   = '0;

    unique case (state_q)
      IDLE: begin
        if (!flush && !trap_q && (count_q < CNT_W'(FIFO_DEPTH))) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          if (pc_in[1:0] != 2'b00) begin
            push                  = 1'b1;
            push_entry.pc         = pc_in;
            push_entry.misaligned = 1'b1;
            trap_d                = 1'b1;
          end else begin
            state_d    = REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = pc_in & ~XLEN'(3);
          end
`else
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_in & ~XLEN'(3);
`endif
        end
      end
      REQ: begin
        if (flush) begin
          mem_req_d = 1'b0;
          state_d   = mem_ready ? DROP : IDLE;
        end else if (mem_ready) begin
          mem_req_d    = 1'b0;
          pc_advance_d = 1'b1;
          state_d      = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (flush) begin
          state_d = mem_rvalid ? IDLE : DROP;
        end else if (mem_rvalid) begin
          push             = 1'b1;
          push_entry.pc    = mem_addr_q;
          push_entry.instr = mem_rdata;
          state_d          = IDLE;
        end
      end
      DROP: begin
        if (mem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) trap_d = 1'b0;
  end

  assign pop = (count_q != '0) && fetch_ready;

  // Shift-register FIFO: entry 0 is always the head, so fetch_* come straight from flops.
  always_comb begin
    fifo_d  = fifo_q;
    count_d = count_q;
    wr_idx  = count_q;

    if (pop) begin
      for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) fifo_d[i] = fifo_q[i+1];
      fifo_d[FIFO_DEPTH-1] = '0;
      count_d = count_q - CNT_W'(1);
      wr_idx  = count_q - CNT_W'(1);
    end

    if (push) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        if (wr_idx == CNT_W'(i)) fifo_d[i] = push_entry;
      end
      count_d = count_d + CNT_W'(1);
    end

    if (flush) begin
      count_d = '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      pc_advance_q <= 1'b0;
      trap_q       <= 1'b0;
      count_q      <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      pc_advance_q <= pc_advance_d;
      trap_q       <= trap_d;
      count_q      <= count_d;
      fifo_q       <= fifo_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign pc_advance  = pc_advance_q;
  assign fetch_valid = (count_q != '0);
  assign fetch_pc    = fifo_q[0].pc;
  assign fetch_instr = fifo_q[0].instr;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_misaligned = fifo_q[0].misaligned;
`else
  assign fetch_misaligned = 1'b0;
`endif

endmodule
